// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and defaults for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fadder.sv
// fadder: one-bit combinational full adder.
// Ports: a, b, cin in; sum_out, c_out out.
module fadder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum_out,
    output logic c_out
);

    assign sum_out = a ^ b ^ cin;
    assign c_out   = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one fadder.
// Ports: clk, rst_n; in_valid/in_ready, a_in, b_in, cin (operand side);
//        out_valid/out_ready, sum, cout (result side, held in HOLD).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] sum_nxt;

    fadder u_fa (
        .a       (a_sr[0]),
        .b       (b_sr[0]),
        .cin     (carry),
        .sum_out (s_bit),
        .c_out   (c_bit)
    );

    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    // The cast form also covers WIDTH=1 without an empty slice.
    assign sum_nxt = WIDTH'({s_bit, sum_sr} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a_in;
                        b_sr     <= b_in;
                        carry    <= cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_ADD;
                    end
                end
                S_ADD: begin
                    sum_sr <= sum_nxt;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= c_bit;
                    if (cnt == CNT_LAST) begin
                        sum       <= sum_nxt;
                        cout      <= c_bit;
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
